// File: rtl/vga_cmd_avl_master.sv
// vga_cmd_avl_master: sequences arm/hold/disarm writes and confirmed frame flips
// into the VGA slave's draw-control window over Avalon-MM.
module vga_cmd_avl_master #(
  parameter int PASS_CYCLES = 76800,
  parameter int STORE_HOLD  = 2,
  parameter int READ_WAIT   = 1,
  parameter int MAX_RETRY   = 3
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [30:0] cmd_data,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        frame_cur,
  output logic [17:0] AVL_ADDR,
  output logic        AVL_WRITE,
  output logic        AVL_READ,
  output logic        AVL_CS,
  output logic [3:0]  AVL_BYTE_EN,
  output logic [31:0] AVL_WRITEDATA,
  input  logic [31:0] AVL_READDATA,
  input  logic        AVL_WAITREQUEST
);
  localparam int CW = $clog2(PASS_CYCLES + 1);
  localparam int RW = $clog2(MAX_RETRY + 1);
  typedef enum logic [2:0] {IDLE, ARM, HOLD, DISARM, FLIP_WR, FLIP_RD, FLIP_CHK, FINISH} state_t;
  state_t        state_q, state_d;
  logic [2:0]    op_q, op_d;
  logic [30:0]   data_q, data_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] retry_q, retry_d;
  logic          err_q, err_d, frame_q, frame_d;
  logic [CW-1:0] hold_last;
  logic [17:0]   addr_sel;
  logic          unused_rd;
  assign unused_rd = ^AVL_READDATA[31:1];
  assign hold_last = (op_q == 3'd1) ? CW'(STORE_HOLD - 1) : CW'(PASS_CYCLES - 1);
  assign addr_sel  = (op_q == 3'd0) ? 18'h20001 :
                     (op_q == 3'd1) ? 18'h20002 :
                     (op_q == 3'd2) ? 18'h20004 :
                     (op_q == 3'd3) ? 18'h20008 : 18'h20000;
  // Bus outputs decode purely from state so an async reset drops them at once.
  assign AVL_WRITE     = (state_q == ARM) || (state_q == DISARM) || (state_q == FLIP_WR);
  assign AVL_READ      = (state_q == FLIP_RD);
  assign AVL_CS        = AVL_WRITE || AVL_READ;
  assign AVL_BYTE_EN   = AVL_CS ? 4'hF : 4'h0;
  assign AVL_ADDR      = AVL_CS ? addr_sel : 18'h0;
  assign AVL_WRITEDATA = (state_q == ARM)     ? {1'b1, data_q} :
                         (state_q == DISARM)  ? {1'b0, data_q} :
                         (state_q == FLIP_WR) ? {31'b0, data_q[0]} : 32'h0;
  assign cmd_ready = (state_q == IDLE) && RESET_N;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == FINISH);
  assign err       = err_q;
  assign frame_cur = frame_q;
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    err_d   = err_q;
    frame_d = frame_q;
    case (state_q)
      IDLE: if (cmd_valid) begin
        op_d    = cmd_op;
        data_d  = cmd_data;
        retry_d = '0;
        err_d   = (cmd_op > 3'd4);
        state_d = (cmd_op > 3'd4) ? FINISH : (cmd_op == 3'd4) ? FLIP_WR : ARM;
      end
      ARM: if (!AVL_WAITREQUEST) begin
        state_d = HOLD;
        cnt_d   = '0;
      end
      HOLD: if (cnt_q == hold_last) state_d = DISARM;
            else cnt_d = cnt_q + 1'b1;
      DISARM: if (!AVL_WAITREQUEST) state_d = FINISH;
      FLIP_WR: if (!AVL_WAITREQUEST) begin
        state_d = FLIP_RD;
        cnt_d   = '0;
      end
      FLIP_RD: if (!AVL_WAITREQUEST) begin
        if (cnt_q == CW'(READ_WAIT)) state_d = FLIP_CHK;
        else cnt_d = cnt_q + 1'b1;
      end
      FLIP_CHK: if (AVL_READDATA[0] == data_q[0]) begin
        frame_d = data_q[0];
        state_d = FINISH;
      end else begin
        retry_d = retry_q + 1'b1;
        err_d   = (retry_d == RW'(MAX_RETRY));
        state_d = (retry_d == RW'(MAX_RETRY)) ? FINISH : FLIP_WR;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      op_q    <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      retry_q <= '0;
      err_q   <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
      err_q   <= err_d;
      frame_q <= frame_d;
    end
  end
endmodule

// File: tb/tb_vga_cmd_avl_master.sv
// tb_vga_cmd_avl_master: directed commands with a queued scoreboard of expected
// bus events (accept, write, read start, done) and their cycle spacing.
module tb_vga_cmd_avl_master;
  localparam int P = 100;
  logic        CLK = 0, RESET_N = 0, cmd_valid = 0, AVL_WAITREQUEST = 0;
  logic [2:0]  cmd_op = 0;
  logic [30:0] cmd_data = 0;
  logic        cmd_ready, busy, done, err, frame_cur, AVL_WRITE, AVL_READ, AVL_CS;
  logic [17:0] AVL_ADDR;
  logic [3:0]  AVL_BYTE_EN;
  logic [31:0] AVL_WRITEDATA, AVL_READDATA;
  logic        stale = 0, sframe = 0, store_lat = 0, store_prev = 0, rd_prev = 0;
  int          store_pulses = 0, cyc = 0, last_cyc = 0, checks = 0, errors = 0;
  typedef struct {int kind; logic [17:0] addr; logic [31:0] data; int gap;} ev_t;
  ev_t exp_q[$];

  vga_cmd_avl_master #(.PASS_CYCLES(P)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .busy(busy), .done(done), .err(err),
    .frame_cur(frame_cur), .AVL_ADDR(AVL_ADDR), .AVL_WRITE(AVL_WRITE), .AVL_READ(AVL_READ),
    .AVL_CS(AVL_CS), .AVL_BYTE_EN(AVL_BYTE_EN), .AVL_WRITEDATA(AVL_WRITEDATA),
    .AVL_READDATA(AVL_READDATA), .AVL_WAITREQUEST(AVL_WAITREQUEST));

  always #10 CLK = ~CLK;

  // Slave model: frame register, store latch with rising-edge pulse counter.
  assign AVL_READDATA = stale ? 32'h0 : {31'b0, sframe};
  always @(posedge CLK) begin
    if (AVL_WRITE && !AVL_WAITREQUEST && AVL_ADDR == 18'h20000) sframe <= AVL_WRITEDATA[0];
    if (AVL_WRITE && !AVL_WAITREQUEST && AVL_ADDR == 18'h20002) store_lat <= AVL_WRITEDATA[31];
    store_prev <= store_lat;
    if (store_lat && !store_prev) store_pulses++;
  end

  function automatic void ex(int k, logic [17:0] a, logic [31:0] d, int g);
    exp_q.push_back('{k, a, d, g});
  endfunction

  function automatic void ev(int k, logic [17:0] a, logic [31:0] d);
    int g = cyc - last_cyc;
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL event: got kind=%0d addr=%h data=%h, required no event", k, a, d);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.addr != a || e.data != d || (e.gap >= 0 && e.gap != g)) begin
        errors++;
        $display("FAIL event: got kind=%0d addr=%h data=%h gap=%0d, required kind=%0d addr=%h data=%h gap=%0d",
                 k, a, d, g, e.kind, e.addr, e.data, e.gap);
      end
    end
    last_cyc = cyc;
  endfunction

  // Monitor: kinds 0 accept, 1 write accepted, 2 read start, 3 done.
  always @(negedge CLK) begin
    if (!RESET_N) rd_prev = 0;
    else begin
      cyc++;
      if (cmd_valid && cmd_ready) ev(0, 0, 0);
      if (AVL_WRITE && !AVL_WAITREQUEST) ev(1, AVL_ADDR, AVL_WRITEDATA);
      if (AVL_READ && !rd_prev) ev(2, AVL_ADDR, 0);
      rd_prev = AVL_READ;
      if (done) ev(3, 0, 0);
    end
  end

  task automatic chk(string name, logic [63:0] got, logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got=%h required=%h", name, got, want);
    end
  endtask

  task automatic issue(logic [2:0] op, logic [30:0] d);
    @(posedge CLK); #1;
    cmd_valid = 1; cmd_op = op; cmd_data = d;
    for (int i = 0; i < 500; i++) begin
      @(negedge CLK);
      if (cmd_ready) break;
    end
    @(posedge CLK); #1;
    cmd_valid = 0;
  endtask

  task automatic wait_done(string name);
    for (int i = 0; i < 500; i++) begin
      @(negedge CLK);
      if (done) return;
    end
    checks++; errors++;
    $display("FAIL %s: done timeout, required done pulse", name);
  endtask

  task automatic wait_empty();
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge CLK);
    chk("pending_events", 64'(exp_q.size()), 0);
  endtask

  function automatic logic [63:0] all_out();
    return {cmd_ready, busy, done, err, frame_cur, AVL_WRITE, AVL_READ, AVL_CS,
            AVL_BYTE_EN, AVL_ADDR, AVL_WRITEDATA};
  endfunction

  initial begin
    repeat (3) @(posedge CLK);
    #1 chk("reset_outputs", all_out(), 0);
    @(posedge CLK); #1 RESET_N = 1;
    @(negedge CLK);
    chk("ready_after_reset", {busy, cmd_ready}, 2'b01);
    // Board
    ex(0, 0, 0, -1); ex(1, 18'h20001, 32'h80A04020, 1);
    ex(1, 18'h20001, 32'h00A04020, P + 1); ex(3, 0, 0, 1);
    issue(3'd0, 31'h00A04020);
    wait_done("board");
    @(negedge CLK);
    chk("board_busy_after", {busy, cmd_ready}, 2'b01);
    wait_empty();
    // Store sprite
    ex(0, 0, 0, -1); ex(1, 18'h20002, 32'h80012345, 1);
    ex(1, 18'h20002, 32'h00012345, 3); ex(3, 0, 0, 1);
    issue(3'd1, 31'h12345);
    wait_done("store");
    repeat (2) @(negedge CLK);
    chk("store_pulses", 64'(store_pulses), 1);
    wait_empty();
    // Flip with stale read-back
    stale = 1;
    ex(0, 0, 0, -1);
    for (int i = 0; i < 3; i++) begin
      ex(1, 18'h20000, 32'h1, (i == 0) ? 1 : 3); ex(2, 18'h20000, 0, 1);
    end
    ex(3, 0, 0, 3);
    issue(3'd4, 31'h1);
    wait_done("flip_stale");
    @(negedge CLK);
    chk("flip_stale_err_frame", {err, frame_cur}, 2'b10);
    wait_empty();
    // Flip with correct echo
    stale = 0;
    ex(0, 0, 0, -1); ex(1, 18'h20000, 32'h1, 1); ex(2, 18'h20000, 0, 1); ex(3, 0, 0, 3);
    issue(3'd4, 31'h7FFFFFFF);
    wait_done("flip_ok");
    @(negedge CLK);
    chk("flip_ok_err_frame", {err, frame_cur}, 2'b01);
    wait_empty();
    // Waitrequest stall during ARM
    AVL_WAITREQUEST = 1;
    ex(0, 0, 0, -1); ex(1, 18'h20001, 32'h80000007, 6);
    ex(1, 18'h20001, 32'h00000007, P + 1); ex(3, 0, 0, 1);
    issue(3'd0, 31'h7);
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      chk("stall_stable", {AVL_WRITE, AVL_CS, AVL_READ, AVL_BYTE_EN, AVL_ADDR, AVL_WRITEDATA},
          {3'b110, 4'hF, 18'h20001, 32'h80000007});
    end
    @(posedge CLK); #1 AVL_WAITREQUEST = 0;
    wait_done("stall");
    wait_empty();
    // Reset mid-HOLD, then illegal op
    ex(0, 0, 0, -1); ex(1, 18'h20004, 32'h80000055, 1);
    issue(3'd2, 31'h55);
    repeat (10) @(posedge CLK);
    #3 RESET_N = 0;
    #1 chk("midhold_reset_outputs", all_out(), 0);
    @(posedge CLK); #1 RESET_N = 1;
    @(negedge CLK);
    chk("ready_after_midreset", {cmd_ready, busy, err, frame_cur}, 4'b1000);
    wait_empty();
    ex(0, 0, 0, -1); ex(3, 0, 0, 1);
    issue(3'd6, 31'h0);
    wait_done("illegal");
    @(negedge CLK);
    chk("illegal_err", {err, busy}, 2'b10);
    wait_empty();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/vga_cmd_avl_master.md
Name: vga_cmd_avl_master

Overview:
Avalon-MM master that drives the VGA text/graphics slave's draw-control window (AVL_ADDR[17]=1) from game logic.
Accepts one high-level draw command at a time over a valid/ready handshake. Sequences the arm write (bit31=1), hold interval and disarm write (bit31=0) that the slave's level-sensitive command latches require. Performs frame flips with read-back confirmation.
Sits between the chess game FSM and the VGA slave on the same 50 MHz clock.

Parameters:
PASS_CYCLES, 76800, cycles an arm stays asserted for board/write-sprite/clear-sprite (one full 320x240 WriteX/WriteY scan)
STORE_HOLD, 2, cycles a store-sprite arm stays asserted before disarm
READ_WAIT, 1, fixed read wait states of the slave; readdata is sampled READ_WAIT+1 cycles after AVL_READ rises
MAX_RETRY, 3, frame-flip read-back mismatches tolerated before flagging an error

Ports:
CLK  in  1  system clock, 50 MHz
RESET_N  in  1  asynchronous active-low reset
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted this cycle when cmd_valid&&cmd_ready
cmd_op  in  3  0 board, 1 store sprite, 2 write sprite, 3 clear sprite, 4 frame flip, 5-7 illegal
cmd_data  in  31  payload; copied to AVL_WRITEDATA[30:0]; for flip, bit0 = frame to display
busy  out  1  sequence in progress
done  out  1  one-cycle pulse when a sequence completes (including error completion)
err  out  1  sticky; set on flip retry exhaustion or illegal op; cleared by the next accepted legal command
frame_cur  out  1  last confirmed displayed frame
AVL_ADDR  out  18  word address: board 0x20001, store 0x20002, write 0x20004, clear 0x20008, frame 0x20000
AVL_WRITE  out  1  Avalon write
AVL_READ  out  1  Avalon read
AVL_CS  out  1  asserted with AVL_WRITE or AVL_READ
AVL_BYTE_EN  out  4  always 4'b1111 during transfers, 0 otherwise
AVL_WRITEDATA  out  32  write data
AVL_READDATA  in  32  read data
AVL_WAITREQUEST  in  1  slave stall; tie 0 for the VGA slave

Behaviour:
- Reset (async assert, sync release): all outputs 0, FSM IDLE, counters 0, frame_cur 0.
  - Reset mid-sequence drops AVL_WRITE/AVL_READ immediately.
  - An armed slave latch may remain set; the game FSM must reissue the command after reset.
- cmd_ready = 1 only in IDLE and only while RESET_N is high.
- Acceptance latches cmd_op and cmd_data. The first bus cycle starts on the next clock.
- States: IDLE, ARM, HOLD, DISARM, FLIP_WR, FLIP_RD, FLIP_CHK, FINISH.
- Op 0/2/3 sequence: IDLE -> ARM -> HOLD -> DISARM -> FINISH.
  - ARM: a single write with WRITEDATA = {1, payload}.
  - HOLD: counts PASS_CYCLES cycles with the bus idle.
  - DISARM: write to the same address with WRITEDATA = {0, payload}.
- Op 1: same sequence with a hold of STORE_HOLD cycles.
  - The slave generates its own single-cycle store pulse from the level.
- Op 4 sequence:
  - FLIP_WR writes {31'b0, cmd_data[0]} to 0x20000.
  - FLIP_RD asserts AVL_READ for READ_WAIT+1 cycles.
  - FLIP_CHK compares READDATA[0] to the requested bit.
  - Match: frame_cur updates, go to FINISH.
  - Mismatch: retry count +1, back to FLIP_WR. After MAX_RETRY mismatches, set err and go to FINISH.
- FINISH: done=1 for one cycle, then IDLE.
- Waitrequest: while AVL_WAITREQUEST=1 and a transfer is active, ADDR/WRITEDATA/BYTE_EN/WRITE/READ hold stable and the FSM does not advance.
  - The write completes on the first cycle with waitrequest low.
  - The read wait count starts after waitrequest falls.
- Illegal op (5-7): accepted, no bus traffic, err set, done pulse the following cycle.
- Hold counter width is clog2(PASS_CYCLES+1). The terminal condition is count == hold-1, so the exact hold length is PASS_CYCLES or STORE_HOLD cycles.
- Latency: accept -> first AVL_WRITE is 1 cycle. Board total = 1 + 1 + PASS_CYCLES + 1 + 1 cycles to done.
- cmd_valid toggling while busy is ignored. A command held valid across FINISH is accepted in the IDLE cycle after done.

Test Plan:
1. Board op 0, data 0x00A0_4020 -> write 0x20001 data 0x80A04020; exactly 76800 idle cycles; write 0x20001 data 0x00A04020; done pulse; busy low next cycle.
2. Store sprite op 1, STORE_HOLD=2 -> writes 0x20002 with bit31=1 then bit31=0 exactly 3 cycles apart; slave-side store pulse seen once.
3. Flip op 4, data bit0=1, slave model echoes correctly -> write 0x20000 data 1, read after 2 cycles, frame_cur=1, err=0.
4. Flip with model returning stale 0 -> 3 write/read pairs, then err=1, frame_cur stays 0, done once.
5. AVL_WAITREQUEST high for 5 cycles during ARM -> signals stable for those cycles; HOLD starts only after the accepted write.
6. Reset_N low mid-HOLD of op 2 -> outputs zero immediately; after release cmd_ready=1; illegal op 6 then gives err=1, no bus cycle, done pulse.
